rf_write_buffer: RTL and testbench

Write-side companion to the 4×16 register file in the pipelined core: collects register write-backs from the pipeline through a valid/ready handshake, queues them in a small FIFO, and drains them one per cycle onto the register file's write port (write/addr/data). Two combinational lookup ports let decode read the newest value still pending in the buffer, so queued writes are never invisible to readers.

---
 rtl/rf_write_buffer_pkg.sv | 13 +
 rtl/rf_wbuf_match.sv | 33 +++
 rtl/rf_write_buffer.sv | 93 +++++++++
 tb/tb_rf_write_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_buffer_pkg.sv
// rtl/rf_write_buffer_pkg.sv - shared register-file constants and write-buffer entry type
package rf_write_buffer_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wbuf_match.sv
// rtl/rf_wbuf_match.sv - youngest-match search over pending write-buffer entries
module rf_wbuf_match
    import rf_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      rd_ptr,
    input  logic [CNT_W-1:0]      count,
    input  logic [ADDR_W-1:0]     lk_addr,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [PTR_W-1:0] idx;

    // Walk head to tail so later (younger) matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == lk_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - register write-back FIFO draining onto the RF write port with lookups
module rf_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = rf_write_buffer_pkg::DATA_W,
    parameter int ADDR_W = rf_write_buffer_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_stall,
    output logic                     rf_write,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    input  logic [ADDR_W-1:0]        lk_addr1,
    output logic                     lk_hit1,
    output logic [DATA_W-1:0]        lk_data1,
    input  logic [ADDR_W-1:0]        lk_addr2,
    output logic                     lk_hit2,
    output logic [DATA_W-1:0]        lk_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    import rf_write_buffer_pkg::wb_entry_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    wb_entry_t             head;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  enq;
    logic                  deq;

    // Acceptance looks only at occupancy, never at the concurrent drain.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign enq      = in_valid && in_ready;
    assign deq      = rf_write;

    assign head     = mem[rd_ptr];
    assign rf_write = !empty && !rf_stall;
    assign rf_addr  = empty ? '0 : head.addr;
    assign rf_data  = empty ? '0 : head.data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Entry contents need no reset: lookups and rf_* are qualified by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {in_addr, in_data};
        end
    end

    rf_wbuf_match #(.DEPTH(DEPTH)) u_match1 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .lk_addr (lk_addr1),
        .hit     (lk_hit1),
        .data    (lk_data1)
    );

    rf_wbuf_match #(.DEPTH(DEPTH)) u_match2 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .lk_addr (lk_addr2),
        .hit     (lk_hit2),
        .data    (lk_data2)
    );

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - self-checking bench for rf_write_buffer against a queue model
module tb_rf_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic        rf_stall;
    logic        rf_write;
    logic [1:0]  rf_addr;
    logic [15:0] rf_data;
    logic [1:0]  lk_addr1;
    logic        lk_hit1;
    logic [15:0] lk_data1;
    logic [1:0]  lk_addr2;
    logic        lk_hit2;
    logic [15:0] lk_data2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;

    logic [17:0] model_q[$];
    logic [17:0] dut_log[$];
    bit          model_ok = 1'b0;
    int          log_idx = 0;

    rf_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_stall (rf_stall),
        .rf_write (rf_write),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .lk_addr1 (lk_addr1),
        .lk_hit1  (lk_hit1),
        .lk_data1 (lk_data1),
        .lk_addr2 (lk_addr2),
        .lk_hit2  (lk_hit2),
        .lk_data2 (lk_data2),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_lookup(input logic [1:0] a);
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i][17:16] == a) return {1'b1, model_q[i][15:0]};
        end
        return 17'h0;
    endfunction

    // Queue model and observed RF write log, both advanced at the active edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            model_q.delete();
            model_ok = 1'b1;
        end else begin
            if (rf_write) dut_log.push_back({rf_addr, rf_data});
            if (model_ok) begin
                bit do_deq;
                do_deq = (model_q.size() > 0) && !rf_stall;
                if (in_valid && model_q.size() < DEPTH) model_q.push_back({in_addr, in_data});
                if (do_deq) void'(model_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [16:0] l1;
            logic [16:0] l2;
            l1 = model_lookup(lk_addr1);
            l2 = model_lookup(lk_addr2);
            chk("count", 32'(count), 32'(model_q.size()));
            chk("empty", 32'(empty), 32'(model_q.size() == 0));
            chk("full", 32'(full), 32'(model_q.size() == DEPTH));
            chk("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
            chk("rf_write", 32'(rf_write), 32'(model_q.size() > 0 && !rf_stall));
            chk("rf_head", {14'h0, rf_addr, rf_data}, model_q.size() > 0 ? 32'(model_q[0]) : 32'h0);
            chk("lk1", {15'h0, lk_hit1, lk_data1}, 32'(l1));
            chk("lk2", {15'h0, lk_hit2, lk_data2}, 32'(l2));
        end
    end

    task automatic cyc(input logic v, input logic [1:0] a, input logic [15:0] d, input logic st);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        rf_stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_log(input string name, input logic [1:0] a, input logic [15:0] d);
        chk(name, log_idx < dut_log.size() ? 32'(dut_log[log_idx]) : 32'hFFFF_FFFF, 32'({a, d}));
        log_idx++;
    endtask

    initial begin
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        rf_stall = 1'b0;
        lk_addr1 = 2'd0;
        lk_addr2 = 2'd0;
        reset_n  = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        reset_n = 1'b1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Single write shows on the RF port exactly one cycle after enqueue.
        cyc(1, 2, 16'h1234, 0);
        chk("single_write", 32'(rf_write), 32'd1);
        chk("single_addr", 32'(rf_addr), 32'd2);
        chk("single_data", 32'(rf_data), 32'h1234);
        cyc(0, 0, 0, 0);
        chk("single_empty", 32'(empty), 32'd1);
        expect_log("log_single", 2, 16'h1234);

        // Fill under stall, fifth offer refused, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1, 2'(i), 16'hA000 + 16'(i), 1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(in_ready), 32'd0);
        cyc(1, 0, 16'hBEEF, 1);
        chk("fill_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("fill_drained", 32'(empty), 32'd1);
        for (int i = 0; i < 4; i++) expect_log("log_fill", 2'(i), 16'hA000 + 16'(i));

        // Same-register ordering and youngest-match lookup.
        lk_addr1 = 2'd1;
        lk_addr2 = 2'd3;
        cyc(1, 1, 16'h0011, 1);
        cyc(1, 1, 16'h0022, 1);
        chk("same_hit1", 32'(lk_hit1), 32'd1);
        chk("same_data1", 32'(lk_data1), 32'h0022);
        chk("same_hit2", 32'(lk_hit2), 32'd0);
        chk("same_data2", 32'(lk_data2), 32'h0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        expect_log("log_same_a", 1, 16'h0011);
        expect_log("log_same_b", 1, 16'h0022);

        // Sustained enqueue+dequeue at count 2 across pointer wrap.
        cyc(1, 0, 16'h0100, 1);
        cyc(1, 1, 16'h0101, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 2'(i + 2), 16'h0102 + 16'(i), 0);
            chk("steady_count", 32'(count), 32'd2);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) expect_log("log_wrap", 2'(i), 16'h0100 + 16'(i));

        // Full while draining: offer refused, count drops to 3.
        for (int i = 0; i < 4; i++) cyc(1, 2'(i), 16'h0200 + 16'(i), 1);
        cyc(1, 3, 16'h02FF, 0);
        chk("fulldrain_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) expect_log("log_fulldrain", 2'(i), 16'h0200 + 16'(i));
        chk("fulldrain_nolate", 32'(dut_log.size()), 32'(log_idx));

        // Reset with three entries queued discards them.
        for (int i = 0; i < 3; i++) cyc(1, 2'(i), 16'h0300 + 16'(i), 1);
        reset_n = 1'b0;
        cyc(1, 3, 16'h03FF, 1);
        reset_n  = 1'b1;
        rf_stall = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rstmid_empty", 32'(empty), 32'd1);
        chk("rstmid_rf_write", 32'(rf_write), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("rstmid_nolog", 32'(dut_log.size()), 32'(log_idx));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
